// File: rtl/clk_div_prog.sv
// Runtime-programmable multi-channel clock-enable generator: per-channel tick strobe and ~50% div_clk at clk/N.
// Configuration changes are deferred to each channel's period boundary so outputs never runt or glitch.
module clk_div_prog #(
    parameter  int NCH     = 4,
    parameter  int CNT_W   = 16,
    parameter  int DEF_DIV = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   div_clk
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT_L = CNT_W'(DEF_DIV - 1);

    logic [CNT_W-1:0] div_q  [NCH];
    logic [CNT_W-1:0] div_d  [NCH];
    logic [CNT_W-1:0] cnt_q  [NCH];
    logic [CNT_W-1:0] cnt_d  [NCH];
    logic [CNT_W-1:0] pdiv_q [NCH];
    logic [CNT_W-1:0] pdiv_d [NCH];
    logic [NCH-1:0]   en_q, en_d;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   pen_q, pen_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   dclk_q, dclk_d;
    logic [NCH-1:0]   hit;

    // Divisors 0 and 1 both mean "every cycle".
    function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
        return (d < TWO) ? ONE : d;
    endfunction

    function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] e);
        logic [CNT_W:0] s;
        s = {1'b0, e} + {{CNT_W{1'b0}}, 1'b1};
        return s[CNT_W:1];
    endfunction

    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend_q[i];
        end
        hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hit[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        pdiv_d = pdiv_q;
        en_d   = en_q;
        pend_d = pend_q;
        pen_d  = pen_q;
        tick_d = tick_q;
        dclk_d = dclk_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (en_q[i]) begin
                if (sync || (cnt_q[i] == eff_div(div_q[i]) - ONE)) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    dclk_d[i] = 1'b1;
                    if (pend_q[i]) begin
                        div_d[i]  = pdiv_q[i];
                        en_d[i]   = pen_q[i];
                        pend_d[i] = 1'b0;
                        if (!pen_q[i]) begin
                            tick_d[i] = 1'b0;
                            dclk_d[i] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d[i]  = cnt_q[i] + ONE;
                    tick_d[i] = 1'b0;
                    dclk_d[i] = (cnt_q[i] + ONE) < high_len(eff_div(div_q[i]));
                end
                // Applying the old request above happens first, so a same-edge accept is kept.
                if (hit[i]) begin
                    pdiv_d[i] = cfg_div;
                    pen_d[i]  = cfg_en;
                    pend_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
                dclk_d[i] = 1'b0;
                if (hit[i]) begin
                    div_d[i] = cfg_div;
                    en_d[i]  = cfg_en;
                    if (cfg_en) cnt_d[i] = eff_div(cfg_div) - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                div_q[i]  <= DEF_DIV_L;
                cnt_q[i]  <= DEF_CNT_L;
                pdiv_q[i] <= '0;
            end
            en_q   <= '1;
            pend_q <= '0;
            pen_q  <= '0;
            tick_q <= '0;
            dclk_q <= '0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            pdiv_q <= pdiv_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            pen_q  <= pen_d;
            tick_q <= tick_d;
            dclk_q <= dclk_d;
        end
    end

    assign pending = pend_q;
    assign tick    = tick_q;
    assign div_clk = dclk_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: phase-based reference model feeding a per-cycle scoreboard queue.
module tb_clk_div_prog;

    localparam int NCH     = 4;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 8;
    localparam int CH_W    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;
    logic             sync;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   div_clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NCH-1:0] t;
        logic [NCH-1:0] d;
        logic [NCH-1:0] p;
    } exp_t;
    exp_t sb[$];

    // Model: a running channel sits at phase ph of period P; outputs are live only after its first period start.
    int m_div  [NCH];
    int m_ph   [NCH];
    int m_pdiv [NCH];
    bit m_run  [NCH];
    bit m_live [NCH];
    bit m_pend [NCH];
    bit m_pen  [NCH];

    bit last_rdy;
    int tcount, first_t, second_t;

    clk_div_prog #(
        .NCH(NCH),
        .CNT_W(CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_en(cfg_en),
        .sync(sync),
        .pending(pending),
        .tick(tick),
        .div_clk(div_clk)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d < 2) ? 1 : d;
    endfunction

    function automatic bit model_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = DEF_DIV;
            m_ph[i]   = eff(DEF_DIV) - 1;
            m_run[i]  = 1'b1;
            m_live[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_pen[i]  = 1'b0;
            m_pdiv[i] = 0;
        end
    endtask

    task automatic model_edge(input bit acc, input int ch, input int dv, input bit en, input bit s);
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            bit h;
            h = acc && (ch == i);
            if (m_run[i]) begin
                if (s || (m_ph[i] == eff(m_div[i]) - 1)) begin
                    m_ph[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_run[i]  = m_pen[i];
                        m_pend[i] = 1'b0;
                    end
                    m_live[i] = m_run[i];
                end else begin
                    m_ph[i] = m_ph[i] + 1;
                end
                if (h) begin
                    m_pdiv[i] = dv;
                    m_pen[i]  = en;
                    m_pend[i] = 1'b1;
                end
            end else if (h) begin
                m_div[i] = dv;
                m_run[i] = en;
                if (en) m_ph[i] = eff(dv) - 1;
            end
            e.t[i] = m_live[i] && (m_ph[i] == 0);
            e.d[i] = m_live[i] && (m_ph[i] < (eff(m_div[i]) + 1) / 2);
            e.p[i] = m_pend[i];
        end
        sb.push_back(e);
    endtask

    task automatic cycle(input bit v, input int ch, input int dv, input bit en, input bit s,
                         output bit dut_rdy);
        exp_t e;
        bit   mr;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_en    = en;
        sync      = s;
        #1;
        mr = model_ready(ch);
        check("cfg_ready", cfg_ready, mr);
        dut_rdy = cfg_ready;
        model_edge(v && mr, ch, dv, en, s);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("tick", tick, e.t);
        check("div_clk", div_clk, e.d);
        check("pending", pending, e.p);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0, last_rdy);
    endtask

    task automatic send(input int ch, input int dv, input bit en);
        int n;
        n = 0;
        last_rdy = 1'b0;
        while (!last_rdy && n < 200) begin
            cycle(1'b1, ch, dv, en, 1'b0, last_rdy);
            n++;
        end
        if (!last_rdy) check("cfg_accept_timeout", last_rdy, 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        sync      = 1'b0;
        model_reset();
        #2;
        check("reset_tick", tick, 0);
        check("reset_div_clk", div_clk, 0);
        check("reset_pending", pending, 0);
        check("reset_ready", cfg_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divide-by-8 on every channel
        for (int n = 1; n <= 20; n++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0, last_rdy);
            check("t1_tick0", tick[0], (n % 8) == 1);
            check("t1_dclk0", div_clk[0], ((n - 1) % 8) < 4);
        end

        // Mid-period reprogram of ch1, then a second request that must stall
        send(1, 5, 1'b1);
        idle(25);
        send(1, 7, 1'b1);
        send(1, 3, 1'b1);
        idle(30);

        // Stop ch2 at its boundary, then restart it from the stopped state
        send(2, 8, 1'b0);
        idle(20);
        send(2, 3, 1'b1);
        idle(12);

        // Degenerate divisors
        send(3, 0, 1'b1);
        idle(12);
        send(3, 1, 1'b1);
        idle(6);

        // Phase alignment with sync
        send(0, 6, 1'b1);
        send(3, 4, 1'b1);
        idle(10);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, last_rdy);
        check("t6_sync_all_tick", tick, 4'hF);
        for (int n = 2; n <= 25; n++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0, last_rdy);
            check("t6_tick0", tick[0], ((n - 1) % 6) == 0);
            check("t6_tick3", tick[3], ((n - 1) % 4) == 0);
        end

        // Maximum period
        send(1, 65535, 1'b1);
        tcount   = 0;
        first_t  = -1;
        second_t = -1;
        for (int n = 1; n <= 65540; n++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0, last_rdy);
            if (tick[1]) begin
                tcount++;
                if (first_t < 0) first_t = n;
                else if (second_t < 0) second_t = n;
            end
        end
        check("t5_max_tick_count", tcount, 2);
        check("t5_max_gap", second_t - first_t, 65535);

        // Asynchronous reset with a request outstanding
        send(1, 9, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_tick", tick, 0);
        check("rst_async_div_clk", div_clk, 0);
        check("rst_async_pending", pending, 0);
        check("rst_async_ready", cfg_ready, 1);
        model_reset();
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_tick", tick, 0);
        rst_n = 1'b1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
